cam_fifo_read_ctrl: RTL and testbench

Sequences readout of one camera frame from the pixel FIFO into a downstream valid/ready consumer (display/UART path). It is paced by the single-cycle FIFO read strobe from the clock divider: at most one FIFO word per strobe. A pulse on capture_req starts the frame, and a row/column counter tracks position within it. It also reports frame completion and FIFO underruns, and supports abort mid-frame.

---
 rtl/cam_fifo_read_ctrl.sv | 144 ++++++++++++++
 tb/tb_cam_fifo_read_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_fifo_read_ctrl.sv
// cam_fifo_read_ctrl
// Reads one camera frame out of the pixel FIFO and hands each pixel to a
// valid/ready consumer. FIFO reads are paced by the divider strobe, with at
// most one word per strobe. The block tracks the row/column of the presented
// pixel, pulses frame_done after the last pixel is accepted, and counts
// strobes that found the FIFO empty while a word was wanted.
//
// Ports:
//   clk_24M       24 MHz system clock
//   reset         synchronous, active-high
//   fifo_tick     one-cycle read-pacing strobe
//   capture_req   one-cycle request to read a frame (ignored while busy)
//   abort         one-cycle request to cancel the current frame
//   fifo_empty    camera FIFO empty flag
//   fifo_dout     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    one-cycle FIFO pop
//   pix_data      pixel to consumer
//   pix_valid     pixel available
//   pix_ready     consumer accepts pixel
//   col, row      position of pix_data within the frame
//   busy          high whenever the controller is not idle
//   frame_done    one-cycle pulse after the last pixel is accepted
//   underrun_cnt  saturating count of strobes that found the FIFO empty
module cam_fifo_read_ctrl #(
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk_24M,
  input  logic              reset,
  input  logic              fifo_tick,
  input  logic              capture_req,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        underrun_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PRESENT,
    DONE
  } state_t;

  state_t state;

  logic last_col;
  logic last_row;

  assign last_col = (col == COL_W'(COLS - 1));
  assign last_row = (row == ROW_W'(ROWS - 1));

  // The pop must land in the same cycle as the strobe, so it is decoded from
  // the state register rather than registered. An abort in this cycle does
  // not cancel it; the popped word is simply never latched.
  assign fifo_rd_en = (state == FETCH) && fifo_tick && !fifo_empty;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      state        <= IDLE;
      pix_data     <= '0;
      pix_valid    <= 1'b0;
      col          <= '0;
      row          <= '0;
      frame_done   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_req) begin
            col          <= '0;
            row          <= '0;
            underrun_cnt <= '0;
            state        <= FETCH;
          end
        end

        FETCH: begin
          if (abort) begin
            state <= IDLE;
          end else if (fifo_tick) begin
            if (!fifo_empty) begin
              state <= LATCH;
            end else if (underrun_cnt != '1) begin
              underrun_cnt <= underrun_cnt + 8'd1;
            end
          end
        end

        // fifo_dout is valid now, one cycle after the pop.
        LATCH: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            pix_data  <= fifo_dout;
            pix_valid <= 1'b1;
            state     <= PRESENT;
          end
        end

        PRESENT: begin
          if (abort) begin
            pix_valid <= 1'b0;
            state     <= IDLE;
          end else if (pix_ready) begin
            pix_valid <= 1'b0;
            if (last_col && last_row) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              if (last_col) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
              state <= FETCH;
            end
          end
        end

        // frame_done is high for exactly this one cycle.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_fifo_read_ctrl.sv
module tb_cam_fifo_read_ctrl;

  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int COL_W  = 2;
  localparam int ROW_W  = 1;
  localparam int DATA_W = 8;

  logic              clk_24M;
  logic              reset;
  logic              fifo_tick;
  logic              capture_req;
  logic              abort;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              busy;
  logic              frame_done;
  logic [7:0]        underrun_cnt;

  cam_fifo_read_ctrl #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk_24M     (clk_24M),
    .reset       (reset),
    .fifo_tick   (fifo_tick),
    .capture_req (capture_req),
    .abort       (abort),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .col         (col),
    .row         (row),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun_cnt(underrun_cnt)
  );

  initial clk_24M = 1'b0;
  always #21 clk_24M = ~clk_24M;

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
  endtask

  // ---------------- FIFO model and expected-pixel queue ----------------
  typedef struct {
    logic [7:0] d;
    int         r;
    int         c;
  } exp_t;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  bit         force_empty = 1'b0;
  int         pop_idx = 0;

  assign fifo_empty = force_empty || (fifo_q.size() == 0);

  initial fifo_dout = '0;

  // Every word the DUT pops becomes the next expected pixel of the frame;
  // its position is simply its index within the frame.
  always @(posedge clk_24M) begin
    logic [7:0] d;
    if (fifo_rd_en && fifo_q.size() > 0) begin
      d = fifo_q.pop_front();
      fifo_dout <= d;
      if (!abort && !reset) begin
        exp_q.push_back('{d: d, r: pop_idx / COLS, c: pop_idx % COLS});
        pop_idx++;
      end
    end
  end

  // ---------------- tick generator ----------------
  int tick_period = 0;
  initial begin
    int cnt = 0;
    fifo_tick = 1'b0;
    forever begin
      @(posedge clk_24M);
      #1;
      cnt++;
      if (tick_period > 0 && cnt >= tick_period) begin
        fifo_tick = 1'b1;
        cnt = 0;
      end else begin
        fifo_tick = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cycle      = 0;
  int ticks_seen = 0;
  int done_seen  = 0;
  int pops_seen  = 0;
  int last_pop   = -100;
  int done_due   = -1;
  logic       prev_rd = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;
  logic [COL_W-1:0] prev_col = '0;
  logic [ROW_W-1:0] prev_row = '0;

  always @(negedge clk_24M) begin
    exp_t e;
    cycle++;
    if (fifo_tick) ticks_seen++;
    if (frame_done) done_seen++;
    if (fifo_rd_en) pops_seen++;
    if (reset) begin
      exp_q.delete();
      done_due = -1;
    end else begin
      if (fifo_rd_en) begin
        check_eq("rd_en_while_empty", int'(fifo_empty), 0);
        check_eq("rd_en_back_to_back", int'(prev_rd), 0);
        check_eq("rd_en_while_valid", int'(pix_valid), 0);
        last_pop = cycle;
      end
      if (pix_valid && !prev_valid)
        check_eq("pop_to_valid_latency", cycle - last_pop, 2);
      if (pix_valid && prev_valid && !prev_ready) begin
        check_eq("hold_data", int'(pix_data), int'(prev_data));
        check_eq("hold_col", int'(col), int'(prev_col));
        check_eq("hold_row", int'(row), int'(prev_row));
      end
      if (frame_done || done_due == cycle)
        check_eq("frame_done", int'(frame_done), int'(done_due == cycle));
      if (abort && busy) begin
        exp_q.delete();
      end else if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pixel: got data 0x%0h with no expected pixel", pix_data);
        end else begin
          e = exp_q.pop_front();
          check_eq("pix_data", int'(pix_data), int'(e.d));
          check_eq("pix_col", int'(col), e.c);
          check_eq("pix_row", int'(row), e.r);
          if (e.r == ROWS - 1 && e.c == COLS - 1) done_due = cycle + 1;
        end
      end
    end
    prev_rd    = fifo_rd_en;
    prev_valid = pix_valid;
    prev_ready = pix_ready;
    prev_data  = pix_data;
    prev_col   = col;
    prev_row   = row;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_24M);
    #1;
  endtask

  task automatic preload(input logic [7:0] base);
    fifo_q.delete();
    for (int i = 0; i < COLS * ROWS; i++) fifo_q.push_back(base + 8'(i));
  endtask

  task automatic start_frame();
    pop_idx = 0;
    capture_req = 1'b1;
    step();
    capture_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_pix_data"}, int'(pix_data), 0);
    check_eq({tag, "_pix_valid"}, int'(pix_valid), 0);
    check_eq({tag, "_col"}, int'(col), 0);
    check_eq({tag, "_row"}, int'(row), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_frame_done"}, int'(frame_done), 0);
    check_eq({tag, "_underrun"}, int'(underrun_cnt), 0);
    check_eq({tag, "_rd_en"}, int'(fifo_rd_en), 0);
  endtask

  task automatic wait_done(input int d0, input int limit, input string name);
    int n = 0;
    while (done_seen == d0 && n < limit) begin
      step();
      n++;
    end
    check_eq({name, "_frame_done_count"}, done_seen - d0, 1);
    check_eq({name, "_busy_after_done"}, int'(busy), 0);
  endtask

  task automatic wait_pixel(input logic [7:0] d, input int limit, input string name);
    int n = 0;
    while (!(pix_valid && pix_data == d) && n < limit) begin
      step();
      n++;
    end
    check_eq({name, "_pixel_seen"}, int'(pix_valid && pix_data == d), 1);
  endtask

  task automatic wait_fifo_level(input int lvl, input int limit, input string name);
    int n = 0;
    while (fifo_q.size() > lvl && n < limit) begin
      step();
      n++;
    end
    check_eq({name, "_fifo_level"}, fifo_q.size(), lvl);
  endtask

  task automatic wait_ticks(input int t0, input int n, input int limit);
    int k = 0;
    while (ticks_seen - t0 < n && k < limit) begin
      step();
      k++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, p0, t0, n, exp_ur;
    reset = 1'b1;
    capture_req = 1'b0;
    abort = 1'b0;
    pix_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_outputs_zero("reset");

    // Idle with ticks running: nothing may happen.
    tick_period = 24;
    p0 = pops_seen;
    repeat (100) step();
    check_outputs_zero("idle");
    check_eq("idle_pops", pops_seen - p0, 0);

    // Plain frame, consumer always ready.
    preload(8'h10);
    tick_period = 4;
    pix_ready = 1'b1;
    d0 = done_seen;
    p0 = pops_seen;
    start_frame();
    wait_done(d0, 400, "frame1");
    check_eq("frame1_final_col", int'(col), COLS - 1);
    check_eq("frame1_final_row", int'(row), ROWS - 1);
    check_eq("frame1_pops", pops_seen - p0, COLS * ROWS);

    // Back-pressure on pixel 3 for 100 cycles.
    preload(8'h10);
    d0 = done_seen;
    start_frame();
    wait_fifo_level(4, 200, "hold");
    pix_ready = 1'b0;
    wait_pixel(8'h13, 20, "hold");
    p0 = pops_seen;
    repeat (100) step();
    check_eq("hold_end_data", int'(pix_data), 'h13);
    check_eq("hold_end_col", int'(col), 3);
    check_eq("hold_end_row", int'(row), 0);
    check_eq("hold_no_pop", pops_seen - p0, 0);
    pix_ready = 1'b1;
    wait_done(d0, 400, "hold");

    // Starved FIFO: underrun count climbs and saturates, then frame completes.
    preload(8'h20);
    force_empty = 1'b1;
    tick_period = 3;
    d0 = done_seen;
    p0 = pops_seen;
    start_frame();
    t0 = ticks_seen;
    wait_ticks(t0, 10, 100);
    check_eq("underrun_10", int'(underrun_cnt), 10);
    wait_ticks(t0, 300, 2000);
    exp_ur = (ticks_seen - t0 > 255) ? 255 : ticks_seen - t0;
    check_eq("underrun_sat", int'(underrun_cnt), exp_ur);
    check_eq("underrun_no_pop", pops_seen - p0, 0);
    force_empty = 1'b0;
    wait_done(d0, 400, "underrun");

    // Abort while presenting pixel 5.
    preload(8'h30);
    force_empty = 1'b1;
    d0 = done_seen;
    start_frame();
    t0 = ticks_seen;
    wait_ticks(t0, 5, 100);
    force_empty = 1'b0;
    wait_fifo_level(2, 400, "abort");
    pix_ready = 1'b0;
    wait_pixel(8'h35, 20, "abort");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_valid", int'(pix_valid), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_col", int'(col), 1);
    check_eq("abort_row", int'(row), 1);
    check_eq("abort_underrun_kept", int'(underrun_cnt), 5);
    repeat (10) step();
    check_eq("abort_no_done", done_seen - d0, 0);
    preload(8'h40);
    pix_ready = 1'b1;
    d0 = done_seen;
    start_frame();
    check_eq("restart_col", int'(col), 0);
    check_eq("restart_row", int'(row), 0);
    check_eq("restart_underrun", int'(underrun_cnt), 0);
    check_eq("restart_busy", int'(busy), 1);
    wait_done(d0, 400, "restart");

    // Capture request while busy is ignored; reset mid-frame clears all.
    preload(8'h50);
    start_frame();
    wait_fifo_level(6, 200, "recap");
    capture_req = 1'b1;
    step();
    capture_req = 1'b0;
    wait_pixel(8'h52, 200, "recap");
    check_eq("recap_col", int'(col), 2);
    check_eq("recap_row", int'(row), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    fifo_q.delete();
    check_outputs_zero("midreset");

    // Randomised frames with random pacing, back-pressure and empties.
    for (int f = 0; f < 6; f++) begin
      fifo_q.delete();
      for (int i = 0; i < COLS * ROWS; i++) fifo_q.push_back(8'($urandom));
      tick_period = int'($urandom_range(1, 5));
      d0 = done_seen;
      start_frame();
      n = 0;
      while (done_seen == d0 && n < 3000) begin
        pix_ready   = ($urandom_range(0, 3) != 0);
        force_empty = ($urandom_range(0, 7) == 0);
        step();
        n++;
      end
      force_empty = 1'b0;
      pix_ready = 1'b1;
      check_eq("rand_frame_done", done_seen - d0, 1);
      check_eq("rand_busy_after", int'(busy), 0);
    end

    repeat (5) step();
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
